// File: rtl/readout_pkg.sv
// Purpose : shared readout definitions (state encoding, word size, default limits, saturating counter helper).
// Latency : n/a (types and constants only).
// Backpressure: n/a. Ports: none; imported by the serializer and by data_socket.
package readout_pkg;

  // Serial words are 16 bits, MSB first; the bit counter wraps once per word.
  localparam int              WORD_BITS          = 16;
  localparam int              BIT_CNT_W          = 4;
  localparam logic [3:0]      LAST_BIT           = 4'(WORD_BITS - 1);

  localparam int              DEF_SYNC_STAGES    = 2;
  localparam int              DEF_START_LEN      = 4;
  localparam int              DEF_GAP_CYCLES     = 6;
  localparam logic [15:0]     DEF_TIMEOUT_CYCLES = 16'hFFFF;
  localparam logic [15:0]     DEF_MAX_WORDS      = 16'd4096;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_WAIT_TX = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_PAD     = 3'd4,
    ST_DRAIN   = 3'd5,
    ST_GAP     = 3'd6
  } rd_state_t;

  // Word counter sticks at all-ones instead of wrapping back to zero.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Purpose : multi-flop synchronizer for one asynchronous level signal.
// Latency : SYNC_STAGES wr_clk1 edges from input change to q.
// Backpressure: none. Ports: wr_clk1, rst_n (async, active-low), d (async in), q (synchronized out, resets to RST_VAL).
module bit_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic wr_clk1,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  generate
    if (SYNC_STAGES == 1) begin : g_single
      always_ff @(posedge wr_clk1 or negedge rst_n) begin
        if (!rst_n) begin
          chain <= RST_VAL;
        end else begin
          chain <= d;
        end
      end
    end else begin : g_chain
      always_ff @(posedge wr_clk1 or negedge rst_n) begin
        if (!rst_n) begin
          chain <= {SYNC_STAGES{RST_VAL}};
        end else begin
          chain <= {chain[SYNC_STAGES-2:0], d};
        end
      end
    end
  endgenerate

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/asic_readout_serializer.sv
// Purpose : requests an ASIC readout, samples its serial line and emits din1/wr_en1 frames padded to 16-bit words.
// Latency : busy/asic_start_readout 1 cycle after start_readout; first wr_en1 SYNC_STAGES+1 cycles after transmit_on falls.
// Backpressure: none; the downstream deserializer must accept one bit per cycle while wr_en1=1.
// Ports: wr_clk1, rst_n | start_readout, asic_transmit_on (active-low, async), asic_dout (async) |
//        asic_start_readout, din1, wr_en1, busy, timeout_err, overflow_err, word_cnt[15:0] (all registered).
module asic_readout_serializer
  import readout_pkg::*;
#(
  parameter int          SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int          START_PULSE_LEN = DEF_START_LEN,
  parameter logic [15:0] TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
  parameter logic [15:0] MAX_WORDS       = DEF_MAX_WORDS,
  parameter int          GAP_CYCLES      = DEF_GAP_CYCLES
) (
  input  logic        wr_clk1,
  input  logic        rst_n,
  input  logic        start_readout,
  input  logic        asic_transmit_on,
  input  logic        asic_dout,
  output logic        asic_start_readout,
  output logic        din1,
  output logic        wr_en1,
  output logic        busy,
  output logic        timeout_err,
  output logic        overflow_err,
  output logic [15:0] word_cnt
);

  localparam logic [15:0] PULSE_LAST = 16'(START_PULSE_LEN - 1);
  localparam logic [15:0] TMO_LAST   = TIMEOUT_CYCLES - 16'd1;
  localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);

  // tx_on_s keeps the ASIC's active-low polarity: 0 means "transmitting".
  logic tx_on_s;
  logic dout_s;

  bit_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_tx (
    .wr_clk1 (wr_clk1),
    .rst_n   (rst_n),
    .d       (asic_transmit_on),
    .q       (tx_on_s)
  );

  bit_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_dout (
    .wr_clk1 (wr_clk1),
    .rst_n   (rst_n),
    .d       (asic_dout),
    .q       (dout_s)
  );

  rd_state_t              state, state_nx;
  logic [15:0]            tmr, tmr_nx;
  logic [BIT_CNT_W-1:0]   bit_cnt, bit_cnt_nx;
  logic [15:0]            word_cnt_nx;
  logic                   tmo_nx, ovf_nx;
  logic                   emit, emit_bit;
  // Goes high one edge after reset release, so a start request that
  // coincides with the release edge is not taken.
  logic                   armed;

  always_comb begin
    state_nx    = state;
    tmr_nx      = 16'd0;
    bit_cnt_nx  = bit_cnt;
    word_cnt_nx = word_cnt;
    tmo_nx      = timeout_err;
    ovf_nx      = overflow_err;
    emit        = 1'b0;
    emit_bit    = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (start_readout && armed) begin
          state_nx    = ST_START;
          tmo_nx      = 1'b0;
          ovf_nx      = 1'b0;
          word_cnt_nx = 16'd0;
          bit_cnt_nx  = '0;
        end
      end

      ST_START: begin
        if (tmr == PULSE_LAST) begin
          state_nx = ST_WAIT_TX;
        end
      end

      ST_WAIT_TX: begin
        // The first data bit is emitted on the same edge the FSM leaves
        // WAIT_TX, so data latency is only the synchronizer plus one flop.
        if (!tx_on_s) begin
          emit     = 1'b1;
          emit_bit = dout_s;
          state_nx = ST_SHIFT;
        end else if (tmr == TMO_LAST) begin
          tmo_nx   = 1'b1;
          state_nx = ST_GAP;
        end
      end

      ST_SHIFT: begin
        if (tx_on_s) begin
          if (bit_cnt == '0) begin
            state_nx = ST_GAP;
          end else begin
            // First pad bit goes out immediately so wr_en1 has no hole.
            emit     = 1'b1;
            state_nx = (bit_cnt == LAST_BIT) ? ST_GAP : ST_PAD;
          end
        end else if ((bit_cnt == '0) && (word_cnt >= MAX_WORDS)) begin
          // Another bit arrived after a full quota of words: drop the rest.
          ovf_nx   = 1'b1;
          state_nx = ST_DRAIN;
        end else begin
          emit     = 1'b1;
          emit_bit = dout_s;
        end
      end

      ST_PAD: begin
        emit = 1'b1;
        if (bit_cnt == LAST_BIT) begin
          state_nx = ST_GAP;
        end
      end

      ST_DRAIN: begin
        if (tx_on_s) begin
          state_nx = ST_GAP;
        end
      end

      ST_GAP: begin
        if (tmr == GAP_LAST) begin
          state_nx = ST_IDLE;
        end
      end

      default: begin
        state_nx = ST_IDLE;
      end
    endcase

    if (emit) begin
      bit_cnt_nx = bit_cnt + 1'b1;
      if (bit_cnt == LAST_BIT) begin
        word_cnt_nx = sat_inc16(word_cnt);
      end
    end

    // Shared dwell timer: restarts on every state change and only runs in
    // the states that have a cycle budget.
    if ((state_nx == state) &&
        ((state == ST_START) || (state == ST_WAIT_TX) || (state == ST_GAP))) begin
      tmr_nx = tmr + 16'd1;
    end
  end

  always_ff @(posedge wr_clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state              <= ST_IDLE;
      tmr                <= 16'd0;
      bit_cnt            <= '0;
      word_cnt           <= 16'd0;
      timeout_err        <= 1'b0;
      overflow_err       <= 1'b0;
      wr_en1             <= 1'b0;
      din1               <= 1'b0;
      busy               <= 1'b0;
      asic_start_readout <= 1'b0;
      armed              <= 1'b0;
    end else begin
      state              <= state_nx;
      tmr                <= tmr_nx;
      bit_cnt            <= bit_cnt_nx;
      word_cnt           <= word_cnt_nx;
      timeout_err        <= tmo_nx;
      overflow_err       <= ovf_nx;
      wr_en1             <= emit;
      din1               <= emit_bit;
      busy               <= (state_nx != ST_IDLE);
      asic_start_readout <= (state_nx == ST_START);
      armed              <= 1'b1;
    end
  end

endmodule

// File: tb/tb_asic_readout_serializer.sv
// Purpose : self-checking bench for asic_readout_serializer (directed vector table + random frames vs. frame-level model).
// Latency : n/a.
// Backpressure: n/a.
module tb_asic_readout_serializer;

  localparam int SYNC      = 2;
  localparam int START_LEN = 4;
  localparam int TMO       = 100;
  localparam int MAXW      = 4;
  localparam int GAP       = 6;

  logic        wr_clk1          = 1'b0;
  logic        rst_n            = 1'b1;
  logic        start_readout    = 1'b0;
  logic        asic_transmit_on = 1'b1;
  logic        asic_dout        = 1'b0;
  logic        asic_start_readout;
  logic        din1;
  logic        wr_en1;
  logic        busy;
  logic        timeout_err;
  logic        overflow_err;
  logic [15:0] word_cnt;

  asic_readout_serializer #(
    .SYNC_STAGES     (SYNC),
    .START_PULSE_LEN (START_LEN),
    .TIMEOUT_CYCLES  (16'(TMO)),
    .MAX_WORDS       (16'(MAXW)),
    .GAP_CYCLES      (GAP)
  ) dut (
    .wr_clk1            (wr_clk1),
    .rst_n              (rst_n),
    .start_readout      (start_readout),
    .asic_transmit_on   (asic_transmit_on),
    .asic_dout          (asic_dout),
    .asic_start_readout (asic_start_readout),
    .din1               (din1),
    .wr_en1             (wr_en1),
    .busy               (busy),
    .timeout_err        (timeout_err),
    .overflow_err       (overflow_err),
    .word_cnt           (word_cnt)
  );

  always #5 wr_clk1 = ~wr_clk1;

  int cyc = 0;
  always @(posedge wr_clk1) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  logic mon_q[$];
  int   mon_rises   = 0;
  int   mon_first   = -1;
  int   mon_pulses  = 0;
  int   mon_tmo_cyc = -1;
  logic wr_prev  = 1'b0;
  logic asr_prev = 1'b0;
  logic tmo_prev = 1'b0;

  always @(negedge wr_clk1) begin
    if (wr_en1) begin
      mon_q.push_back(din1);
      if (!wr_prev) begin
        mon_rises++;
        if (mon_first < 0) mon_first = cyc;
      end
    end
    if (asic_start_readout && !asr_prev) mon_pulses++;
    if (timeout_err && !tmo_prev) mon_tmo_cyc = cyc;
    wr_prev  = wr_en1;
    asr_prev = asic_start_readout;
    tmo_prev = timeout_err;
  end

  task automatic mon_clear();
    mon_q.delete();
    mon_rises   = 0;
    mon_first   = -1;
    mon_pulses  = 0;
    mon_tmo_cyc = -1;
  endtask

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Frame-level reference: N bits sampled while transmit_on is low. The
  // frame keeps at most MAXW words of data, is zero-filled up to a whole
  // word, and an empty frame means the ASIC never answered.
  logic exp_q[$];
  int   m_words;
  logic m_tmo;
  logic m_ovf;

  task automatic build_expected(input int len, input logic [127:0] data);
    int n;
    exp_q.delete();
    m_tmo = (len == 0);
    m_ovf = (len > MAXW * 16);
    n     = m_ovf ? MAXW * 16 : len;
    for (int i = 0; i < n; i++) exp_q.push_back(data[127 - i]);
    while ((exp_q.size() % 16) != 0) exp_q.push_back(1'b0);
    m_words = exp_q.size() / 16;
  endtask

  int fall_cyc, rise_cyc, pulse_end_cyc, busy_fall_cyc;

  task automatic do_frame(input int len, input logic [127:0] data, input int dly,
                          input bit poke, input string tag);
    int n;
    int mism;
    mon_clear();
    @(negedge wr_clk1);
    start_readout = 1'b1;
    @(negedge wr_clk1);
    start_readout = 1'b0;
    check({tag, " accept busy/pulse"}, 32'({busy, asic_start_readout}), 32'h3);
    check({tag, " status cleared"}, 32'({timeout_err, overflow_err, word_cnt}), 32'h0);

    n = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge wr_clk1);
      if (!asic_start_readout) break;
      n++;
    end
    pulse_end_cyc = cyc;
    check({tag, " start pulse width"}, 32'(n), 32'(START_LEN));

    if (poke) begin
      start_readout = 1'b1;
      @(negedge wr_clk1);
      start_readout = 1'b0;
    end
    repeat (dly) @(negedge wr_clk1);

    if (len > 0) begin
      fall_cyc = cyc;
      for (int i = 0; i < len; i++) begin
        asic_transmit_on = 1'b0;
        asic_dout        = data[127 - i];
        @(negedge wr_clk1);
      end
      asic_transmit_on = 1'b1;
      asic_dout        = 1'b0;
      rise_cyc         = cyc;
    end

    for (int k = 0; k < 600 && busy; k++) @(negedge wr_clk1);
    busy_fall_cyc = cyc;
    check({tag, " busy dropped"}, 32'(busy), 32'h0);
    repeat (2) @(negedge wr_clk1);

    build_expected(len, data);
    check({tag, " word_cnt"}, 32'(word_cnt), 32'(m_words));
    check({tag, " timeout_err"}, 32'(timeout_err), 32'(m_tmo));
    check({tag, " overflow_err"}, 32'(overflow_err), 32'(m_ovf));
    check({tag, " wr_en1 cycles"}, 32'(mon_q.size()), 32'(exp_q.size()));
    mism = -1;
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++)
      if (mism < 0 && mon_q[i] !== exp_q[i]) mism = i;
    check({tag, " first bad bit index"}, 32'(mism), 32'hFFFF_FFFF);
    check({tag, " wr_en1 bursts"}, 32'(mon_rises), (exp_q.size() > 0) ? 32'd1 : 32'd0);
    check({tag, " start pulses"}, 32'(mon_pulses), 32'd1);
    if (len > 0) begin
      check({tag, " first bit latency"}, 32'(mon_first - fall_cyc), 32'(SYNC + 1));
    end else begin
      check({tag, " timeout latency"}, 32'(mon_tmo_cyc - pulse_end_cyc), 32'(TMO));
      check({tag, " gap after timeout"}, 32'(busy_fall_cyc - mon_tmo_cyc), 32'(GAP));
    end
  endtask

  typedef struct {
    int           len;
    logic [127:0] data;
    int           dly;
    bit           poke;
    int           exp_words;
    bit           exp_tmo;
    bit           exp_ovf;
    int           exp_tail;   // cycles from transmit_on rise to busy fall; -1 = skip
  } vec_t;

  vec_t vecs[8];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : main
    int   len;
    logic [127:0] data;

    vecs[0] = '{32,  {16'hA5C3, 16'h0F0F, 96'd0},                      3, 1'b0, 2, 1'b0, 1'b0, SYNC + 1 + GAP};
    vecs[1] = '{20,  {32'hDEAD_BEEF, 96'd0},                           5, 1'b0, 2, 1'b0, 1'b0, -1};
    vecs[2] = '{1,   {1'b1, 127'd0},                                   0, 1'b0, 1, 1'b0, 1'b0, -1};
    vecs[3] = '{16,  {16'h8001, 112'd0},                               7, 1'b1, 1, 1'b0, 1'b0, SYNC + 1 + GAP};
    vecs[4] = '{0,   128'd0,                                           0, 1'b1, 0, 1'b1, 1'b0, -1};
    vecs[5] = '{64,  {64'h0123_4567_89AB_CDEF, 64'd0},                 2, 1'b0, 4, 1'b0, 1'b0, SYNC + 1 + GAP};
    vecs[6] = '{100, 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978,     1, 1'b0, 4, 1'b0, 1'b1, SYNC + 1 + GAP};
    vecs[7] = '{17,  {17'h1_FFFF, 111'd0},                             4, 1'b0, 2, 1'b0, 1'b0, -1};

    // Reset state, then a start request coinciding with reset release.
    #1 rst_n = 1'b0;
    @(negedge wr_clk1);
    check("reset outputs", 32'({asic_start_readout, din1, wr_en1, busy, timeout_err, overflow_err, word_cnt}), 32'h0);
    @(negedge wr_clk1);
    rst_n         = 1'b1;
    start_readout = 1'b1;
    @(negedge wr_clk1);
    start_readout = 1'b0;
    check("start at reset release ignored", 32'({busy, asic_start_readout}), 32'h0);
    repeat (3) @(negedge wr_clk1);
    check("still idle after release", 32'(busy), 32'h0);

    // Directed vector table, back-to-back.
    for (int i = 0; i < 8; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      do_frame(vecs[i].len, vecs[i].data, vecs[i].dly, vecs[i].poke, tag);
      check({tag, " hand word_cnt"}, 32'(word_cnt), 32'(vecs[i].exp_words));
      check({tag, " hand errors"}, 32'({timeout_err, overflow_err}), 32'({vecs[i].exp_tmo, vecs[i].exp_ovf}));
      if (vecs[i].exp_tail >= 0)
        check({tag, " busy tail"}, 32'(busy_fall_cyc - rise_cyc), 32'(vecs[i].exp_tail));
    end

    // Randomized frames against the model.
    for (int i = 0; i < 16; i++) begin
      len = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 80));
      data = {$urandom(), $urandom(), $urandom(), $urandom()};
      do_frame(len, data, int'($urandom_range(0, 10)), bit'($urandom_range(0, 1)),
               $sformatf("rand%0d len%0d", i, len));
    end

    // Reset asserted in the middle of SHIFT.
    mon_clear();
    @(negedge wr_clk1);
    start_readout = 1'b1;
    @(negedge wr_clk1);
    start_readout = 1'b0;
    for (int k = 0; k < 40 && asic_start_readout; k++) @(negedge wr_clk1);
    for (int i = 0; i < 24; i++) begin
      asic_transmit_on = 1'b0;
      asic_dout        = i[0];
      @(negedge wr_clk1);
    end
    check("pre-reset busy/wr_en1/word_cnt", 32'({busy, wr_en1, word_cnt}), 32'({1'b1, 1'b1, 16'd1}));
    #2 rst_n = 1'b0;
    #1;
    check("async reset outputs", 32'({asic_start_readout, din1, wr_en1, busy, timeout_err, overflow_err, word_cnt}), 32'h0);
    asic_transmit_on = 1'b1;
    asic_dout        = 1'b0;
    @(negedge wr_clk1);
    @(negedge wr_clk1);
    rst_n = 1'b1;
    do_frame(32, {16'hA5C3, 16'h0F0F, 96'd0}, 2, 1'b0, "post_reset");
    check("post_reset busy tail", 32'(busy_fall_cyc - rise_cyc), 32'(SYNC + 1 + GAP));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
